// File: rtl/m68k_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// m68k_bus_arbiter_if
//
// Handshake bundle between the 68000 bus arbiter and its surroundings: the
// M68K_CLK edge strobes, the raw BR/BGACK pins, the bus-cycle engine's busy
// flag, and the arbiter's grant / BG / tri-state outputs.
//
// Signals
//   c7m_rising    one-c200m-cycle strobe on the M68K_CLK rising edge
//   c7m_falling   one-c200m-cycle strobe on the M68K_CLK falling edge
//   M68K_BR_n     raw asynchronous bus request from an external master
//   M68K_BGACK_n  raw asynchronous bus-grant acknowledge
//   cpu_busy      bus-cycle engine is between S1 and S7
//   cpu_gnt       engine may start a new 68k cycle
//   M68K_BG_n     bus grant to the external master
//   bus_release   top level tri-states AS/UDS/LDS/RW/FC and the address OE
//
// Modports
//   slave   the arbiter itself
//   master  whatever drives the arbiter (top level or testbench)
// -----------------------------------------------------------------------------
interface m68k_bus_arbiter_if;
    logic c7m_rising;
    logic c7m_falling;
    logic M68K_BR_n;
    logic M68K_BGACK_n;
    logic cpu_busy;
    logic cpu_gnt;
    logic M68K_BG_n;
    logic bus_release;

    modport slave (
        input  c7m_rising,
        input  c7m_falling,
        input  M68K_BR_n,
        input  M68K_BGACK_n,
        input  cpu_busy,
        output cpu_gnt,
        output M68K_BG_n,
        output bus_release
    );

    modport master (
        output c7m_rising,
        output c7m_falling,
        output M68K_BR_n,
        output M68K_BGACK_n,
        output cpu_busy,
        input  cpu_gnt,
        input  M68K_BG_n,
        input  bus_release
    );
endinterface : m68k_bus_arbiter_if

// File: rtl/m68k_bus_arbiter.sv
// -----------------------------------------------------------------------------
// m68k_bus_arbiter
//
// Arbitrates the 68000 bus between the PiStorm bus-cycle engine and external
// bus masters using the BR/BG/BGACK protocol. Runs on the 200 MHz Pi clock;
// all M68K_CLK timing comes in as single-cycle edge strobes.
//
// Parameters
//   BG_TIMEOUT   c7m falling edges BG is held without BGACK before the grant
//                is withdrawn (2..255)
//   SYNC_STAGES  synchronizer depth for BR_n / BGACK_n (>= 2)
//
// Ports
//   c200m        Pi clock, everything on the rising edge
//   reset_n      synchronous, active-low reset
//   bus          handshake bundle (slave modport), see m68k_bus_arbiter_if
//   arb_state    current arbitration state, for the status register
//   dma_grants   saturating count of grants that were acknowledged
//   bg_timeouts  saturating count of grants withdrawn for lack of BGACK
// -----------------------------------------------------------------------------
module m68k_bus_arbiter #(
    parameter int BG_TIMEOUT  = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic                c200m,
    input  logic                reset_n,
    m68k_bus_arbiter_if.slave   bus,
    output logic [2:0]          arb_state,
    output logic [7:0]          dma_grants,
    output logic [7:0]          bg_timeouts
);

    typedef enum logic [2:0] {
        S_CPU       = 3'd0,
        S_WAIT_IDLE = 3'd1,
        S_GRANTED   = 3'd2,
        S_DMA       = 3'd3,
        S_RECOVER   = 3'd4
    } arb_state_e;

    localparam logic [7:0] TIMER_LAST = 8'(BG_TIMEOUT - 1);

    // -------------------------------------------------------------------------
    // Input synchronizers. Both pins idle high, so the chains reset to 1 and
    // no phantom request is seen while the chain refills after reset.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] br_sync;
    logic [SYNC_STAGES-1:0] bgack_sync;
    logic                   br;
    logic                   bgack;

    always_ff @(posedge c200m) begin
        if (!reset_n) begin
            br_sync    <= '1;
            bgack_sync <= '1;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the value
            // its predecessor held before this edge, which is what forms a
            // shift chain; blocking ones would collapse it to a single stage.
            br_sync    <= {br_sync[SYNC_STAGES-2:0],    bus.M68K_BR_n};
            bgack_sync <= {bgack_sync[SYNC_STAGES-2:0], bus.M68K_BGACK_n};
        end
    end

    assign br    = ~br_sync[SYNC_STAGES-1];
    assign bgack = ~bgack_sync[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    arb_state_e state;
    arb_state_e next_state;
    logic [7:0] bg_timer;
    logic       timer_expired;

    logic       cpu_gnt_q;
    logic       bg_n_q;
    logic       bus_release_q;

    logic       cpu_gnt_d;
    logic       bg_n_d;
    logic       bus_release_d;
    logic       grant_ack;
    logic       timeout_hit;
    logic       timer_clr;
    logic       timer_inc;

    assign timer_expired = (bg_timer == TIMER_LAST);

    // State register. Reset also drops BG and the bus release immediately, so
    // a reset in the middle of a DMA hands the pins back without a handshake.
    always_ff @(posedge c200m) begin
        if (!reset_n) begin
            state         <= S_CPU;
            cpu_gnt_q     <= 1'b0;
            bg_n_q        <= 1'b1;
            bus_release_q <= 1'b0;
            bg_timer      <= 8'd0;
            dma_grants    <= 8'd0;
            bg_timeouts   <= 8'd0;
        end else begin
            state         <= next_state;
            cpu_gnt_q     <= cpu_gnt_d;
            bg_n_q        <= bg_n_d;
            bus_release_q <= bus_release_d;

            if (timer_clr) begin
                bg_timer <= 8'd0;
            end else if (timer_inc) begin
                bg_timer <= bg_timer + 8'd1;
            end

            if (grant_ack && (dma_grants != 8'hFF)) begin
                dma_grants <= dma_grants + 8'd1;
            end
            if (timeout_hit && (bg_timeouts != 8'hFF)) begin
                bg_timeouts <= bg_timeouts + 8'd1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven,
        // so no latch is inferred for branches that leave the state alone.
        next_state = state;
        case (state)
            S_CPU: begin
                // A takeover by a master that never asked (BGACK without BR)
                // also has to stop the engine, so both qualify here.
                if (bus.c7m_rising && (br || bgack)) begin
                    next_state = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (bus.c7m_falling && !bus.cpu_busy) begin
                    if (br) begin
                        next_state = S_GRANTED;
                    end else if (bgack) begin
                        next_state = S_DMA;
                    end else begin
                        next_state = S_RECOVER;
                    end
                end
            end
            S_GRANTED: begin
                // An acknowledge wins over a withdrawal or timeout landing on
                // the same edge: the master already owns the bus.
                if (bgack) begin
                    next_state = S_DMA;
                end else if (bus.c7m_falling && (!br || timer_expired)) begin
                    next_state = S_RECOVER;
                end
            end
            S_DMA: begin
                // BR is deliberately ignored here; a new request is only
                // served after the engine has had its arbitration point.
                if (!bgack) begin
                    next_state = S_RECOVER;
                end
            end
            S_RECOVER: begin
                if (bus.c7m_falling) begin
                    next_state = S_CPU;
                end
            end
            default: begin
                next_state = S_CPU;
            end
        endcase
    end

    // Output logic. The handshake outputs are registered from the state being
    // entered, so they change on the same edge as the state itself. Because
    // CPU is only left on c7m_rising and only entered on c7m_falling, cpu_gnt
    // can only move on those strobes.
    always_comb begin
        cpu_gnt_d     = (next_state == S_CPU);
        bg_n_d        = (next_state != S_GRANTED);
        bus_release_d = (next_state == S_DMA);

        grant_ack     = (state == S_GRANTED) && bgack;
        // Only an expiry with the request still standing counts as a timeout;
        // a master that drops BR on that edge simply withdrew.
        timeout_hit   = (state == S_GRANTED) && !bgack && bus.c7m_falling &&
                        br && timer_expired;
        // Holding the timer at zero outside GRANTED clears it on entry.
        timer_clr     = (state != S_GRANTED);
        timer_inc     = (state == S_GRANTED) && bus.c7m_falling &&
                        (next_state == S_GRANTED);
    end

    assign bus.cpu_gnt     = cpu_gnt_q;
    assign bus.M68K_BG_n   = bg_n_q;
    assign bus.bus_release = bus_release_q;
    assign arb_state       = state;

endmodule : m68k_bus_arbiter

// File: tb/tb_m68k_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_m68k_bus_arbiter
//
// Self-checking bench: directed vector table, hand-written corner sequences,
// then randomized stimulus compared every cycle with a behavioural model.
// The c7m strobes are generated from a fixed 8-cycle phase counter.
// -----------------------------------------------------------------------------
module tb_m68k_bus_arbiter;

    localparam int T_OUT = 4;
    localparam int SYNC  = 2;
    localparam int P     = 8;   // c200m cycles per c7m period in this bench

    logic       c200m;
    logic       rst_n;
    logic [2:0] arb_state;
    logic [7:0] dma_grants;
    logic [7:0] bg_timeouts;

    m68k_bus_arbiter_if bus_if ();

    m68k_bus_arbiter #(
        .BG_TIMEOUT  (T_OUT),
        .SYNC_STAGES (SYNC)
    ) dut (
        .c200m       (c200m),
        .reset_n     (rst_n),
        .bus         (bus_if),
        .arb_state   (arb_state),
        .dma_grants  (dma_grants),
        .bg_timeouts (bg_timeouts)
    );

    initial begin
        c200m = 1'b0;
        forever #5 c200m = ~c200m;
    end

    int n_total = 0;
    int n_pass  = 0;
    int ph      = P - 1;
    bit last_fell;
    bit last_rose;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [21:0] dut_vec();
        return {arb_state, bus_if.cpu_gnt, bus_if.M68K_BG_n, bus_if.bus_release,
                dma_grants, bg_timeouts};
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model: who owns the bus, derived from the protocol rules.
    // Synchronizer delay is a FIFO of pin samples SYNC edges deep.
    // ------------------------------------------------------------------
    int m_state;
    bit m_gnt, m_bg, m_rel;
    int m_tmr, m_grants, m_touts;
    bit br_q[$];
    bit bgack_q[$];

    function automatic logic [21:0] model_vec();
        return {3'(m_state), m_gnt, m_bg, m_rel, 8'(m_grants), 8'(m_touts)};
    endfunction

    task automatic model_step();
        bit br, bgack, rise, fall;
        if (!rst_n) begin
            m_state = 0; m_gnt = 0; m_bg = 1; m_rel = 0;
            m_tmr = 0; m_grants = 0; m_touts = 0;
            br_q = {}; bgack_q = {};
            for (int i = 0; i < SYNC; i++) begin
                br_q.push_back(1'b1);
                bgack_q.push_back(1'b1);
            end
            return;
        end
        br    = !br_q.pop_front();
        bgack = !bgack_q.pop_front();
        br_q.push_back(bus_if.M68K_BR_n);
        bgack_q.push_back(bus_if.M68K_BGACK_n);
        rise = bus_if.c7m_rising;
        fall = bus_if.c7m_falling;

        if (m_state == 0) begin
            if (rise && (br || bgack)) begin
                m_state = 1; m_gnt = 0;
            end else begin
                m_gnt = 1;
            end
        end else if (m_state == 1) begin
            if (fall && !bus_if.cpu_busy) begin
                if (br) begin
                    m_state = 2; m_bg = 0; m_tmr = 0;
                end else if (bgack) begin
                    m_state = 3; m_rel = 1;
                end else begin
                    m_state = 4;
                end
            end
        end else if (m_state == 2) begin
            if (bgack) begin
                m_state = 3; m_bg = 1; m_rel = 1;
                if (m_grants < 255) m_grants++;
            end else if (fall) begin
                if (!br || m_tmr == T_OUT - 1) begin
                    if (br && m_touts < 255) m_touts++;
                    m_state = 4; m_bg = 1;
                end else begin
                    m_tmr++;
                end
            end
        end else if (m_state == 3) begin
            if (!bgack) begin
                m_state = 4; m_rel = 0;
            end
        end else begin
            if (fall) begin
                m_state = 0; m_gnt = 1;
            end
        end
    endtask

    // One c200m cycle: model consumes the inputs present at the edge, then
    // the strobes advance for the next cycle.
    task automatic tick();
        model_step();
        last_fell = bus_if.c7m_falling;
        last_rose = bus_if.c7m_rising;
        @(posedge c200m);
        #1;
        ph = (ph + 1) % P;
        bus_if.c7m_rising  = (ph == 0);
        bus_if.c7m_falling = (ph == P / 2);
    endtask

    // kind 1: until an edge that consumed c7m_falling; kind 2: c7m_rising
    task automatic run_to(input int kind);
        bit hit = 0;
        for (int k = 0; k < 2 * P; k++) begin
            tick();
            if ((kind == 1) ? last_fell : last_rose) begin
                hit = 1;
                break;
            end
        end
        if (!hit) begin
            n_total++;
            $display("FAIL strobe_wait: no c7m strobe within %0d cycles", 2 * P);
        end
    endtask

    typedef struct {
        bit       br_n;
        bit       bgack_n;
        bit       busy;
        int       adv;      // 0: n cycles, 1: to c7m_falling, 2: to c7m_rising
        int       n;
        logic [21:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit br_n, input bit bgack_n, input bit busy,
                       input int adv, input int n, input int st,
                       input bit gnt, input bit bg, input bit rel,
                       input int grants, input int touts);
        vec_t v;
        v.br_n = br_n; v.bgack_n = bgack_n; v.busy = busy;
        v.adv = adv; v.n = n;
        v.exp = {3'(st), gnt, bg, rel, 8'(grants), 8'(touts)};
        vecs.push_back(v);
    endtask

    initial begin
        rst_n               = 1'b0;
        bus_if.c7m_rising   = 1'b0;
        bus_if.c7m_falling  = 1'b0;
        bus_if.M68K_BR_n    = 1'b1;
        bus_if.M68K_BGACK_n = 1'b1;
        bus_if.cpu_busy     = 1'b0;

        //   br bgk bsy adv n   st gnt bg rel grants touts
        // Idle bus: request, grant, acknowledge, 10 c7m of DMA, release
        add(1, 1, 0, 2, 0,   0, 1, 1, 0, 0, 0);
        add(0, 1, 0, 2, 0,   1, 0, 1, 0, 0, 0);
        add(0, 1, 0, 1, 0,   2, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 2,   2, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1,   3, 0, 1, 1, 1, 0);
        add(1, 0, 0, 0, 80,  3, 0, 1, 1, 1, 0);
        add(1, 1, 0, 0, 2,   3, 0, 1, 1, 1, 0);
        add(1, 1, 0, 0, 1,   4, 0, 1, 0, 1, 0);
        add(1, 1, 0, 1, 0,   0, 1, 1, 0, 1, 0);
        // Request while the engine is busy for several c7m
        add(1, 1, 1, 2, 0,   0, 1, 1, 0, 1, 0);
        add(0, 1, 1, 2, 0,   1, 0, 1, 0, 1, 0);
        add(0, 1, 1, 0, 24,  1, 0, 1, 0, 1, 0);
        add(0, 1, 0, 1, 0,   2, 0, 0, 0, 1, 0);
        // No acknowledge: grant withdrawn on the 4th falling edge
        add(0, 1, 0, 1, 0,   2, 0, 0, 0, 1, 0);
        add(0, 1, 0, 1, 0,   2, 0, 0, 0, 1, 0);
        add(0, 1, 0, 1, 0,   2, 0, 0, 0, 1, 0);
        add(0, 1, 0, 1, 0,   4, 0, 1, 0, 1, 1);
        add(0, 1, 0, 1, 0,   0, 1, 1, 0, 1, 1);
        // Request withdrawn during GRANTED
        add(1, 1, 0, 2, 0,   0, 1, 1, 0, 1, 1);
        add(0, 1, 0, 2, 0,   1, 0, 1, 0, 1, 1);
        add(0, 1, 0, 1, 0,   2, 0, 0, 0, 1, 1);
        add(1, 1, 0, 1, 0,   4, 0, 1, 0, 1, 1);
        add(1, 1, 0, 1, 0,   0, 1, 1, 0, 1, 1);

        // Reset state
        repeat (3) tick();
        check("reset_state", dut_vec(), {3'd0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0});
        rst_n = 1'b1;
        tick();
        check("gnt_after_reset", bus_if.cpu_gnt, 1);

        // Directed table
        foreach (vecs[i]) begin
            bus_if.M68K_BR_n    = vecs[i].br_n;
            bus_if.M68K_BGACK_n = vecs[i].bgack_n;
            bus_if.cpu_busy     = vecs[i].busy;
            if (vecs[i].adv == 0) begin
                repeat (vecs[i].n) tick();
            end else begin
                run_to(vecs[i].adv);
            end
            check($sformatf("vec%0d", i), dut_vec(), vecs[i].exp);
        end

        // BGACK arrives on the very edge the timer expires: DMA wins
        bus_if.M68K_BR_n = 1'b0;
        run_to(2);
        check("same_req", arb_state, 1);
        run_to(1);
        repeat (3) run_to(1);
        check("same_timer3", {arb_state, bus_if.M68K_BG_n}, {3'd2, 1'b0});
        repeat (5) tick();
        bus_if.M68K_BGACK_n = 1'b0;
        repeat (2) tick();
        check("same_pre", {arb_state, bus_if.M68K_BG_n}, {3'd2, 1'b0});
        tick();
        check("same_edge", dut_vec(), {3'd3, 1'b0, 1'b1, 1'b1, 8'd2, 8'd1});
        // BR stays asserted through DMA and is ignored
        repeat (16) tick();
        check("dma_ignores_br", {arb_state, bus_if.M68K_BG_n}, {3'd3, 1'b1});
        bus_if.M68K_BGACK_n = 1'b1;
        bus_if.M68K_BR_n    = 1'b1;
        repeat (3) tick();
        check("dma_exit", {arb_state, bus_if.cpu_gnt, bus_if.bus_release}, {3'd4, 1'b0, 1'b0});
        run_to(1);
        check("dma_exit_gnt", {arb_state, bus_if.cpu_gnt}, {3'd0, 1'b1});

        // Unsolicited takeover, then reset in the middle of the DMA
        bus_if.M68K_BGACK_n = 1'b0;
        run_to(2);
        check("takeover_wait", arb_state, 1);
        run_to(1);
        check("takeover_dma", dut_vec(), {3'd3, 1'b0, 1'b1, 1'b1, 8'd2, 8'd1});
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        check("reset_mid_dma", dut_vec(), {3'd0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0});
        bus_if.M68K_BGACK_n = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        check("gnt_after_dma_reset", bus_if.cpu_gnt, 1);

        // Randomized stimulus against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(39) == 0) bus_if.M68K_BR_n    = ~bus_if.M68K_BR_n;
            if ($urandom_range(49) == 0) bus_if.M68K_BGACK_n = ~bus_if.M68K_BGACK_n;
            if ($urandom_range(9)  == 0) bus_if.cpu_busy     = ~bus_if.cpu_busy;
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(799) == 0) rst_n = 1'b0;
            tick();
            check($sformatf("rand%0d", c), dut_vec(), model_vec());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_m68k_bus_arbiter
